// File: rtl/sub_io_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sub_io_decoder
// Purpose  : Registered address decoder and I/O control block for the
//            sub-CPU bus. It decodes the sub-CPU address into VRAM plane
//            selects, a ROM select and an I/O window. The I/O window emits one
//            read or write strobe per access. The block also holds the BUSY
//            flag, the IRQ request latch and the VRAM page-enable register.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            cpu_addr/rw/valid/ba/din - sub-CPU bus inputs
//            busy_clr, irq_set        - main-side handshake pulses
//            vram_cs, rom_cs, io_cs   - registered region selects
//            io_rd_stb, io_wr_stb     - one-clock strobes, one bit per offset
//            busy, irq, vpage_en      - status/control registers
//            cpu_dout                 - status readback (offset 3 read)
// Revision : 1.0 - initial release
// ============================================================================
module sub_io_decoder #(
    parameter int                ADDR_W     = 16,
    parameter int                NUM_PLANES = 3,
    parameter int                PLANE_LOG2 = 14,
    parameter logic [ADDR_W-1:0] ROM_BASE   = 16'hE000,
    parameter logic [ADDR_W-1:0] IO_BASE    = 16'hD400,
    parameter int                IO_LOG2    = 4,
    localparam int               IO_N       = 2**IO_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic                  cpu_rw,
    input  logic                  cpu_valid,
    input  logic                  cpu_ba,
    input  logic [7:0]            cpu_din,
    input  logic                  busy_clr,
    input  logic                  irq_set,
    output logic [NUM_PLANES-1:0] vram_cs,
    output logic                  rom_cs,
    output logic                  io_cs,
    output logic [IO_N-1:0]       io_rd_stb,
    output logic [IO_N-1:0]       io_wr_stb,
    output logic                  busy,
    output logic                  irq,
    output logic [NUM_PLANES-1:0] vpage_en,
    output logic [7:0]            cpu_dout
);

    // Fixed I/O offsets with side effects.
    localparam int               c_OFF_BUSY   = 0;
    localparam int               c_OFF_IRQ    = 1;
    localparam int               c_OFF_VPAGE  = 2;
    localparam logic [IO_LOG2-1:0] c_OFF_STATUS = IO_LOG2'(3);
    localparam logic [IO_N-1:0]  c_STB_ONE    = IO_N'(1);

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                  w_q;
    logic                  w_rom_hit;
    logic                  w_io_hit;
    logic [IO_LOG2-1:0]    w_off;
    logic [NUM_PLANES-1:0] w_plane_hit;
    logic                  w_start;
    logic [IO_N-1:0]       w_stb_oh;
    logic [7:0]            w_status;
    logic                  w_stat_rd;

    // Only the low NUM_PLANES data bits reach the page-enable register.
    logic [7-NUM_PLANES:0] w_unused_din;

    // Registers
    logic                  r_prev_q;
    logic [ADDR_W-1:0]     r_prev_addr;
    logic [NUM_PLANES-1:0] r_vram_cs;
    logic                  r_rom_cs;
    logic                  r_io_cs;
    logic [IO_N-1:0]       r_rd_stb;
    logic [IO_N-1:0]       r_wr_stb;
    logic                  r_busy;
    logic                  r_irq;
    logic [NUM_PLANES-1:0] r_vpage;
    logic [NUM_PLANES-1:0] r_din;
    logic [7:0]            r_dout;

    assign w_unused_din = cpu_din[7:NUM_PLANES];

    assign w_q       = cpu_valid & ~cpu_ba;
    assign w_rom_hit = (cpu_addr >= ROM_BASE);
    // ROM has priority, so an I/O window placed inside ROM is shadowed.
    assign w_io_hit  = (cpu_addr[ADDR_W-1:IO_LOG2] == IO_BASE[ADDR_W-1:IO_LOG2])
                       & ~w_rom_hit;
    assign w_off     = cpu_addr[IO_LOG2-1:0];

    generate
        for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
            localparam logic [ADDR_W-PLANE_LOG2-1:0] c_PLANE = (ADDR_W-PLANE_LOG2)'(p);
            assign w_plane_hit[p] = (cpu_addr[ADDR_W-1:PLANE_LOG2] == c_PLANE)
                                    & ~w_rom_hit & ~w_io_hit;
        end
    endgenerate

    // A new access begins when a qualified cycle follows an idle one or when
    // the address changes under a continuing valid. A held access therefore
    // starts exactly once.
    assign w_start   = w_q & (~r_prev_q | (cpu_addr != r_prev_addr));
    assign w_stb_oh  = c_STB_ONE << w_off;

    // Status byte: bit7 busy, bit6 irq, low bits page enables.
    assign w_status  = {r_busy, r_irq, {(6-NUM_PLANES){1'b0}}, r_vpage};
    assign w_stat_rd = w_start & w_io_hit & cpu_rw & (w_off == c_OFF_STATUS);

    // ------------------------------------------------------------------
    // Registered outputs and control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_q    <= 1'b0;
            r_prev_addr <= '0;
            r_vram_cs   <= '0;
            r_rom_cs    <= 1'b0;
            r_io_cs     <= 1'b0;
            r_rd_stb    <= '0;
            r_wr_stb    <= '0;
            r_busy      <= 1'b1;
            r_irq       <= 1'b0;
            r_vpage     <= '1;
            r_din       <= '0;
            r_dout      <= 8'h00;
        end else begin
            r_prev_q    <= w_q;
            r_prev_addr <= cpu_addr;

            // Selects follow the qualified address with one cycle of latency.
            // If cpu_ba rises, they drop on the next edge.
            r_vram_cs   <= {NUM_PLANES{w_q}} & w_plane_hit & r_vpage;
            r_rom_cs    <= w_q & w_rom_hit;
            r_io_cs     <= w_q & w_io_hit;

            r_rd_stb    <= (w_start & w_io_hit &  cpu_rw) ? w_stb_oh : '0;
            r_wr_stb    <= (w_start & w_io_hit & ~cpu_rw) ? w_stb_oh : '0;

            // Capture write data at access start. The page register is loaded
            // from this copy in the strobe cycle.
            if (w_start) begin
                r_din  <= cpu_din[NUM_PLANES-1:0];
                r_dout <= w_stat_rd ? w_status : 8'h00;
            end

            // The strobe-cycle set wins over a simultaneous main-side clear.
            if (r_wr_stb[c_OFF_BUSY]) begin
                r_busy <= 1'b1;
            end else if (busy_clr) begin
                r_busy <= 1'b0;
            end

            // A main-side IRQ request wins over a simultaneous acknowledge read.
            if (irq_set) begin
                r_irq <= 1'b1;
            end else if (r_rd_stb[c_OFF_IRQ]) begin
                r_irq <= 1'b0;
            end

            if (r_wr_stb[c_OFF_VPAGE]) begin
                r_vpage <= r_din;
            end
        end
    end

    assign vram_cs   = r_vram_cs;
    assign rom_cs    = r_rom_cs;
    assign io_cs     = r_io_cs;
    assign io_rd_stb = r_rd_stb;
    assign io_wr_stb = r_wr_stb;
    assign busy      = r_busy;
    assign irq       = r_irq;
    assign vpage_en  = r_vpage;
    assign cpu_dout  = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_sub_io_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_io_decoder
// Purpose  : Self-checking bench for sub_io_decoder. It runs a directed
//            sequence and then randomized bus traffic. An access-level
//            reference model checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_io_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rw = 1'b1;
    logic        cpu_valid = 1'b0;
    logic        cpu_ba = 1'b0;
    logic [7:0]  cpu_din = '0;
    logic        busy_clr = 1'b0;
    logic        irq_set = 1'b0;
    logic [2:0]  vram_cs;
    logic        rom_cs;
    logic        io_cs;
    logic [15:0] io_rd_stb;
    logic [15:0] io_wr_stb;
    logic        busy;
    logic        irq;
    logic [2:0]  vpage_en;
    logic [7:0]  cpu_dout;

    sub_io_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_rw    (cpu_rw),
        .cpu_valid (cpu_valid),
        .cpu_ba    (cpu_ba),
        .cpu_din   (cpu_din),
        .busy_clr  (busy_clr),
        .irq_set   (irq_set),
        .vram_cs   (vram_cs),
        .rom_cs    (rom_cs),
        .io_cs     (io_cs),
        .io_rd_stb (io_rd_stb),
        .io_wr_stb (io_wr_stb),
        .busy      (busy),
        .irq       (irq),
        .vpage_en  (vpage_en),
        .cpu_dout  (cpu_dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks the current access and the pending effects
    // of the strobe that is visible this cycle.
    // ------------------------------------------------------------------
    logic [2:0]  m_vcs;
    logic        m_rom, m_io;
    logic [15:0] m_rd, m_wr;
    logic        m_busy, m_irq;
    logic [2:0]  m_vp;
    logic [7:0]  m_dout;
    logic        m_dchk;
    logic        m_pq;
    logic [15:0] m_pa;
    logic [2:0]  m_din;

    task automatic model_edge();
        logic q, st, in_rom, in_io, in_vram, nb, ni;
        logic [2:0]  nv;
        logic [15:0] one;
        int pl, off;
        one = 16'd1;
        if (reset) begin
            m_vcs = 0; m_rom = 0; m_io = 0; m_rd = 0; m_wr = 0;
            m_busy = 1; m_irq = 0; m_vp = 3'b111; m_dout = 0; m_dchk = 1;
            m_pq = 0; m_pa = 0; m_din = 0;
            return;
        end
        q       = cpu_valid && !cpu_ba;
        st      = q && (!m_pq || cpu_addr != m_pa);
        in_rom  = (cpu_addr >= 16'hE000);
        in_io   = !in_rom && (int'(cpu_addr) / 16 == 16'hD400 / 16);
        pl      = int'(cpu_addr) / 16384;
        off     = int'(cpu_addr) % 16;
        in_vram = !in_rom && !in_io && (pl < 3);

        // effects of the strobe presently on the outputs
        nb = m_wr[0] ? 1'b1 : (busy_clr ? 1'b0 : m_busy);
        ni = irq_set ? 1'b1 : (m_rd[1] ? 1'b0 : m_irq);
        nv = m_wr[2] ? m_din : m_vp;

        m_vcs = (q && in_vram) ? ((3'b001 << pl) & m_vp) : 3'b000;
        m_rom = q && in_rom;
        m_io  = q && in_io;
        m_rd  = (st && in_io && cpu_rw)  ? (one << off) : 16'h0;
        m_wr  = (st && in_io && !cpu_rw) ? (one << off) : 16'h0;
        if (st) begin
            m_din = cpu_din[2:0];
            if (in_io && cpu_rw && off == 3) begin
                m_dout = {m_busy, m_irq, 3'b000, m_vp};
                m_dchk = 1;
            end else begin
                m_dchk = 0;
            end
        end
        m_busy = nb; m_irq = ni; m_vp = nv;
        m_pq = q; m_pa = cpu_addr;
    endtask

    task automatic compare_all();
        chk("vram_cs",   32'(vram_cs),   32'(m_vcs));
        chk("rom_cs",    32'(rom_cs),    32'(m_rom));
        chk("io_cs",     32'(io_cs),     32'(m_io));
        chk("io_rd_stb", 32'(io_rd_stb), 32'(m_rd));
        chk("io_wr_stb", 32'(io_wr_stb), 32'(m_wr));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("irq",       32'(irq),       32'(m_irq));
        chk("vpage_en",  32'(vpage_en),  32'(m_vp));
        if (m_dchk) chk("cpu_dout", 32'(cpu_dout), 32'(m_dout));
    endtask

    // One bus cycle: drive inputs, clock, update model, compare.
    task automatic step(input logic v, input logic ba, input logic [15:0] a,
                        input logic rw, input logic [7:0] d,
                        input logic bc, input logic is, input logic rs);
        cpu_valid = v; cpu_ba = ba; cpu_addr = a; cpu_rw = rw; cpu_din = d;
        busy_clr = bc; irq_set = is; reset = rs;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input logic bc, input logic is);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, bc, is, 1'b0);
    endtask

    initial begin
        int hold;
        logic [15:0] ra;
        logic        rrw, rv;
        logic [7:0]  rd;

        // reset
        step(0, 0, 16'h0000, 1, 8'h00, 0, 0, 1);
        step(0, 0, 16'h0000, 1, 8'h00, 0, 0, 1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_vpage", 32'(vpage_en), 32'h7);
        chk("rst_dout", 32'(cpu_dout), 32'h0);
        idle(0, 0);

        // plane and ROM decode
        step(1, 0, 16'h0000, 1, 8'h00, 0, 0, 0); chk("plane0", 32'(vram_cs), 32'h1); idle(0, 0);
        step(1, 0, 16'h4000, 1, 8'h00, 0, 0, 0); chk("plane1", 32'(vram_cs), 32'h2); idle(0, 0);
        step(1, 0, 16'h8000, 1, 8'h00, 0, 0, 0); chk("plane2", 32'(vram_cs), 32'h4); idle(0, 0);
        step(1, 0, 16'hE000, 1, 8'h00, 0, 0, 0); chk("rom", 32'(rom_cs), 32'h1); idle(0, 0);
        step(1, 0, 16'hC000, 1, 8'h00, 0, 0, 0);
        chk("hole", 32'({vram_cs, rom_cs, io_cs}), 32'h0); idle(0, 0);

        // page enable write then masked plane selects
        step(1, 0, 16'hD402, 0, 8'h05, 0, 0, 0); chk("vp_stb", 32'(io_wr_stb), 32'h4);
        idle(0, 0); chk("vp_val", 32'(vpage_en), 32'h5);
        step(1, 0, 16'h4000, 1, 8'h00, 0, 0, 0); chk("plane1_off", 32'(vram_cs), 32'h0); idle(0, 0);
        step(1, 0, 16'h8000, 1, 8'h00, 0, 0, 0); chk("plane2_on", 32'(vram_cs), 32'h4); idle(0, 0);

        // busy handshake
        idle(1, 0); chk("busy_clr", 32'(busy), 32'd0);
        step(1, 0, 16'hD400, 0, 8'h00, 0, 0, 0); chk("busy_stb", 32'(io_wr_stb), 32'h1);
        idle(0, 0); chk("busy_set", 32'(busy), 32'd1);
        idle(1, 0); chk("busy_clr2", 32'(busy), 32'd0);
        step(1, 0, 16'hD400, 0, 8'h00, 0, 0, 0);
        idle(1, 0); chk("busy_setwins", 32'(busy), 32'd1);

        // irq latch and held read
        idle(0, 1); chk("irq_set", 32'(irq), 32'd1);
        for (int i = 0; i < 5; i++) step(1, 0, 16'hD401, 1, 8'h00, 0, 0, 0);
        chk("irq_ack", 32'(irq), 32'd0);
        idle(0, 0);
        step(1, 0, 16'hD403, 1, 8'h00, 0, 0, 0); chk("status", 32'(cpu_dout), 32'h85);
        idle(0, 0);

        // bus-available suppression
        step(1, 1, 16'hD405, 1, 8'h00, 0, 0, 0);
        step(1, 1, 16'hD405, 1, 8'h00, 0, 0, 0);
        chk("ba_io", 32'(io_cs), 32'd0); chk("ba_stb", 32'(io_rd_stb), 32'h0);
        step(1, 0, 16'hD405, 1, 8'h00, 0, 0, 0); chk("ba_rel", 32'(io_rd_stb), 32'h20);
        step(1, 0, 16'hD405, 1, 8'h00, 0, 0, 0);
        idle(0, 0);

        // reset during a held write
        step(1, 0, 16'hD402, 0, 8'h02, 0, 0, 0);
        step(1, 0, 16'hD402, 0, 8'h02, 0, 0, 1);
        chk("mid_rst_vp", 32'(vpage_en), 32'h7); chk("mid_rst_busy", 32'(busy), 32'd1);
        step(1, 0, 16'hD402, 0, 8'h02, 0, 0, 0); chk("post_rst_stb", 32'(io_wr_stb), 32'h4);
        step(1, 0, 16'hD402, 0, 8'h02, 0, 0, 0); chk("post_rst_vp", 32'(vpage_en), 32'h2);
        idle(0, 0);

        // randomized traffic
        hold = 0; ra = 0; rrw = 1; rv = 0; rd = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0:       ra = 16'($urandom);
                    1:       ra = 16'hD400 | 16'($urandom_range(0, 15));
                    2:       ra = {2'($urandom_range(0, 3)), 14'($urandom)};
                    default: ra = 16'hE000 + 16'($urandom_range(0, 8191));
                endcase
                rrw  = 1'($urandom);
                rd   = 8'($urandom);
                rv   = ($urandom_range(0, 9) != 0);
                hold = $urandom_range(1, 4);
            end
            step(rv, ($urandom_range(0, 9) == 0), ra, rrw, rd,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 59) == 0));
            hold--;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
